ro_count_bank: RTL and testbench
================================

# ro_count_bank

Measurement front end for the ring-oscillator sensor array. The block counts rising edges on 16 asynchronous ring-oscillator outputs over a programmable window of system-clock cycles. It then snapshots the 16 counts and presents them on a flattened bus with a valid/ready handshake. The downstream 16-input adder tree consumes this bus to form the aggregate power-activity sample.

## Interface
Parameters:
- N_RO, 16, number of ring-oscillator channels.
- CNT_W, 32, width of each per-channel edge counter.
- WIN_W, 32, width of the window-length register.

Ports:
- clk, input, 1, system clock; all logic is on its rising edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, one-cycle request to begin a measurement; honoured only in IDLE.
- abort, input, 1, cancels COUNT or HOLD and returns the block to IDLE.
- window_len, input, WIN_W, window length in clk cycles; sampled on an accepted start.
- ro_in, input, N_RO, raw asynchronous oscillator outputs.
- busy, output, 1, high in COUNT and HOLD.
- cnt_valid, output, 1, snapshot available (HOLD state).
- cnt_ready, input, 1, consumer accepts the snapshot.
- cnt_flat, output, N_RO*CNT_W, snapshot bus; channel i is bits [i*CNT_W +: CNT_W].
- overflow, output, N_RO, per-channel saturation flag; valid together with cnt_flat.

## Operation
- **Synchronisers:** each ro_in bit passes through a 2-flop synchroniser and then a third history flop. The edge pulse is s2 & ~s3.
- **Edge-rate limit:** at most one edge per channel per cycle is counted. Oscillators faster than clk/2 alias; this is accepted behaviour.
- **FSM states:** IDLE, COUNT, HOLD.
- **IDLE:**
  - start=1 with window_len≠0 goes to COUNT. On that transition: clear all counters and overflow flags, and load win_cnt with window_len.
  - start with window_len=0 is ignored.
- **COUNT:**
  - Each cycle, every channel whose edge pulse is high increments its counter.
  - Counters saturate at 2^CNT_W−1. Incrementing at saturation sets the sticky overflow[i].
  - win_cnt decrements each cycle. The cycle in which win_cnt==1 is the last counted cycle.
  - After that cycle, go to HOLD. On entry, the counts including the last cycle's edges are copied into the cnt_flat and overflow output registers.
- **HOLD:**
  - cnt_valid=1. cnt_flat and overflow stay stable until the transfer.
  - cnt_valid & cnt_ready goes to IDLE; cnt_valid falls the next cycle.
- **start outside IDLE:** ignored, including start in the same cycle as the HOLD→IDLE transfer.
- **abort:** in COUNT or HOLD, goes to IDLE next cycle with cnt_valid=0. The snapshot is discarded and cnt_flat keeps its last value. abort has priority over a simultaneous transfer. abort in IDLE has no effect.
- **Synchronisers run continuously:** they are never cleared except by rst.

## Timing
- **Reset values:** busy=0, cnt_valid=0, cnt_flat=0, overflow=0, FSM=IDLE, all synchroniser flops=0.
- **Reset mid-measurement:** state is lost immediately and asynchronously; no snapshot is produced.
- **Counted window:** start accepted at edge t. Counted edge pulses are those present in cycles t+1 through t+W, where W=window_len.
- **Output latency:** cnt_valid rises at edge t+W+1. busy rises at edge t+1.
- **Synchroniser latency:** ro_in to edge pulse is 3 clk edges. Transitions within the last 3 cycles of the window fall into the next measurement or are lost.
- **Back-to-back rate:** minimum spacing between accepted starts is W+2 cycles, with cnt_ready held high.
- **Arithmetic:** counters are unsigned CNT_W-bit, saturating. win_cnt is unsigned WIN_W-bit.

## Test plan
- **Isolated pulses:** window_len=100; ro_in[5] gets 3 isolated pulses (each 4 cycles high, 4 low), all inside the window after synchroniser delay; all other channels held at 0 → channel 5 reads 3, others 0, overflow=0, cnt_valid at t+101.
- **Max rate:** ro_in[0] toggles every clk cycle (square wave at clk/2) from 10 cycles before start; window_len=64 → channel 0 reads 32.
- **Saturation:** CNT_W=4; 20 edges on channel 2 within the window → channel 2 reads 15, overflow[2]=1, other overflow bits 0.
- **Handshake hold:** cnt_ready held low 10 cycles into HOLD → cnt_valid and cnt_flat stable all 10 cycles; a start pulse in that interval is ignored. Raise cnt_ready → cnt_valid=0 next cycle, busy=0.
- **Abort and zero window:**
  - abort at cycle 20 of a 100-cycle window → busy=0 next cycle, no cnt_valid.
  - A following start with window_len=0 is ignored.
  - A following start with window_len=8 completes normally.
- **Reset mid-measurement:** assert rst during COUNT → all outputs 0 immediately. After release, a new measurement counts only post-release edges.

Source files
------------

// File: rtl/ro_count_bank.sv
// ro_count_bank
// Counts rising edges on a bank of asynchronous ring-oscillator outputs over
// a programmable window of system-clock cycles. At the end of the window it
// snapshots all counts and saturation flags and offers them downstream on a
// valid/ready handshake.

module ro_count_bank #(
    parameter int N_RO  = 16,
    parameter int CNT_W = 32,
    parameter int WIN_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WIN_W-1:0]        window_len,
    input  logic [N_RO-1:0]         ro_in,
    output logic                    busy,
    output logic                    cnt_valid,
    input  logic                    cnt_ready,
    output logic [N_RO*CNT_W-1:0]   cnt_flat,
    output logic [N_RO-1:0]         overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    state_t state;

    // Synchroniser chain: s1/s2 resolve metastability, s3 holds the previous
    // synchronised value so a rising edge shows up as s2 & ~s3.
    logic [N_RO-1:0] sync_s1;
    logic [N_RO-1:0] sync_s2;
    logic [N_RO-1:0] sync_s3;
    logic [N_RO-1:0] edge_pulse;

    // Live per-channel counters and sticky saturation flags.
    logic [CNT_W-1:0] cnt_q    [N_RO];
    logic [CNT_W-1:0] cnt_next [N_RO];
    logic [N_RO-1:0]  ovf_q;
    logic [N_RO-1:0]  ovf_next;

    // Remaining cycles in the current window.
    logic [WIN_W-1:0] win_cnt;

    // Flattened view of the counters after this cycle's increments, which is
    // what gets captured on HOLD entry.
    logic [N_RO*CNT_W-1:0] snap_flat;

    // Control decodes.
    logic accept_start;
    logic counting;
    logic last_cycle;
    logic transfer;

    // Synchronisers run continuously and are cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
            sync_s3 <= '0;
        end else begin
            sync_s1 <= ro_in;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
        end
    end

    assign edge_pulse = sync_s2 & ~sync_s3;

    // Control decodes shared by the counter bank and the FSM.
    always_comb begin
        accept_start = 1'b0;
        counting     = 1'b0;
        last_cycle   = 1'b0;
        transfer     = 1'b0;
        case (state)
            ST_IDLE: begin
                accept_start = start && (window_len != '0);
            end
            ST_COUNT: begin
                counting   = !abort;
                last_cycle = !abort && (win_cnt == WIN_ONE);
            end
            ST_HOLD: begin
                transfer = !abort && cnt_ready;
            end
            default: begin
                accept_start = 1'b0;
            end
        endcase
    end

    // Saturating increment for every channel with an edge pulse this cycle.
    always_comb begin
        ovf_next = ovf_q;
        for (int i = 0; i < N_RO; i++) begin
            cnt_next[i] = cnt_q[i];
            if (edge_pulse[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_next[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Pack the post-increment counts into the output bus layout.
    always_comb begin
        snap_flat = '0;
        for (int i = 0; i < N_RO; i++) begin
            snap_flat[i*CNT_W +: CNT_W] = cnt_next[i];
        end
    end

    // Counter bank: cleared when a measurement is accepted, advanced while
    // counting, frozen otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_RO; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else if (accept_start) begin
            for (int i = 0; i < N_RO; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else if (counting) begin
            for (int i = 0; i < N_RO; i++) begin
                cnt_q[i] <= cnt_next[i];
            end
            ovf_q <= ovf_next;
        end
    end

    // Window down-counter: loaded on an accepted start, decremented in COUNT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (accept_start) begin
            win_cnt <= window_len;
        end else if (counting) begin
            win_cnt <= win_cnt - WIN_ONE;
        end
    end

    // Measurement FSM with registered busy/valid and the output snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cnt_valid <= 1'b0;
            cnt_flat  <= '0;
            overflow  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_start) begin
                        state <= ST_COUNT;
                        busy  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (last_cycle) begin
                        state     <= ST_HOLD;
                        cnt_valid <= 1'b1;
                        cnt_flat  <= snap_flat;
                        overflow  <= ovf_next;
                    end
                end
                ST_HOLD: begin
                    if (abort || transfer) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        cnt_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    cnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_count_bank.sv
// Directed testbench for ro_count_bank. A default-width instance covers the
// main behaviour; a second instance with 4-bit counters shares the same
// stimulus and is used for the saturation scenario.

module tb_ro_count_bank;

    localparam int N_RO  = 16;
    localparam int CNT_W = 32;
    localparam int WIN_W = 32;
    localparam int SAT_W = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  abort;
    logic                  cnt_ready;
    logic [WIN_W-1:0]      window_len;
    logic [N_RO-1:0]       ro_in;

    logic                  busy;
    logic                  cnt_valid;
    logic [N_RO*CNT_W-1:0] cnt_flat;
    logic [N_RO-1:0]       overflow;

    logic                  busy4;
    logic                  cnt_valid4;
    logic [N_RO*SAT_W-1:0] cnt_flat4;
    logic [N_RO-1:0]       overflow4;

    logic [N_RO*CNT_W-1:0] exp_flat;
    logic [N_RO*SAT_W-1:0] exp_flat4;

    int n_checks = 0;
    int n_pass   = 0;

    ro_count_bank #(.N_RO(N_RO), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .window_len(window_len), .ro_in(ro_in), .busy(busy),
        .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
        .cnt_flat(cnt_flat), .overflow(overflow)
    );

    ro_count_bank #(.N_RO(N_RO), .CNT_W(SAT_W), .WIN_W(WIN_W)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .window_len(window_len), .ro_in(ro_in), .busy(busy4),
        .cnt_valid(cnt_valid4), .cnt_ready(cnt_ready),
        .cnt_flat(cnt_flat4), .overflow(overflow4)
    );

    // Free-running system clock, 10 time units per period.
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; cnt_ready = 1'b0;
        window_len = '0; ro_in = '0;
        step(3);
        n_checks++;
        if ({busy, cnt_valid, overflow} !== {2'b00, 16'h0000})
            $display("[TB] FAIL reset_ctrl got busy=%b valid=%b ovf=%h want 0/0/0000", busy, cnt_valid, overflow);
        else n_pass++;
        n_checks++;
        if (cnt_flat !== '0) $display("[TB] FAIL reset_flat got %h want 0", cnt_flat);
        else n_pass++;
        n_checks++;
        if ({busy4, cnt_valid4, overflow4, cnt_flat4} !== '0)
            $display("[TB] FAIL reset_sat got busy=%b valid=%b ovf=%h flat=%h want all 0", busy4, cnt_valid4, overflow4, cnt_flat4);
        else n_pass++;
        rst = 1'b0;
        step(3);
        n_checks++;
        if ({busy, cnt_valid} !== 2'b00) $display("[TB] FAIL idle_after_reset got busy=%b valid=%b want 0/0", busy, cnt_valid);
        else n_pass++;
    endtask

    task automatic test_isolated_pulses();
        start = 1'b1; window_len = 100;
        step(1);
        start = 1'b0;
        n_checks++;
        if ({busy, cnt_valid} !== 2'b10) $display("[TB] FAIL iso_busy_rise got busy=%b valid=%b want 1/0", busy, cnt_valid);
        else n_pass++;
        for (int k = 1; k <= 100; k++) begin
            ro_in[5] = ((k >= 10 && k < 14) || (k >= 18 && k < 22) || (k >= 26 && k < 30));
            if (k == 100) begin
                n_checks++;
                if (cnt_valid !== 1'b0) $display("[TB] FAIL iso_valid_early got %b want 0", cnt_valid);
                else n_pass++;
            end
            step(1);
        end
        exp_flat = '0;
        exp_flat[5*CNT_W +: CNT_W] = 32'd3;
        n_checks++;
        if ({busy, cnt_valid} !== 2'b11) $display("[TB] FAIL iso_valid_rise got busy=%b valid=%b want 1/1", busy, cnt_valid);
        else n_pass++;
        n_checks++;
        if (cnt_flat !== exp_flat) $display("[TB] FAIL iso_counts got %h want %h", cnt_flat, exp_flat);
        else n_pass++;
        n_checks++;
        if (overflow !== 16'h0000) $display("[TB] FAIL iso_overflow got %h want 0000", overflow);
        else n_pass++;
        cnt_ready = 1'b1;
        step(1);
        cnt_ready = 1'b0;
        n_checks++;
        if ({busy, cnt_valid} !== 2'b00) $display("[TB] FAIL iso_transfer got busy=%b valid=%b want 0/0", busy, cnt_valid);
        else n_pass++;
    endtask

    task automatic test_max_rate();
        ro_in = '0;
        step(4);
        for (int k = 0; k < 10; k++) begin
            ro_in[0] = ~ro_in[0];
            step(1);
        end
        ro_in[0] = ~ro_in[0];
        start = 1'b1; window_len = 64;
        step(1);
        start = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            ro_in[0] = ~ro_in[0];
            step(1);
        end
        ro_in = '0;
        exp_flat = '0;
        exp_flat[0 +: CNT_W] = 32'd32;
        n_checks++;
        if (cnt_valid !== 1'b1) $display("[TB] FAIL max_valid got %b want 1", cnt_valid);
        else n_pass++;
        n_checks++;
        if (cnt_flat !== exp_flat) $display("[TB] FAIL max_counts got %h want %h", cnt_flat, exp_flat);
        else n_pass++;
        cnt_ready = 1'b1;
        step(1);
        cnt_ready = 1'b0;
    endtask

    task automatic test_saturation();
        ro_in = '0;
        step(4);
        start = 1'b1; window_len = 64;
        step(1);
        start = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            if (k >= 5 && k < 45) ro_in[2] = ~ro_in[2];
            step(1);
        end
        exp_flat4 = '0;
        exp_flat4[2*SAT_W +: SAT_W] = 4'd15;
        exp_flat = '0;
        exp_flat[2*CNT_W +: CNT_W] = 32'd20;
        n_checks++;
        if (cnt_valid4 !== 1'b1) $display("[TB] FAIL sat_valid got %b want 1", cnt_valid4);
        else n_pass++;
        n_checks++;
        if (cnt_flat4 !== exp_flat4) $display("[TB] FAIL sat_counts got %h want %h", cnt_flat4, exp_flat4);
        else n_pass++;
        n_checks++;
        if (overflow4 !== 16'h0004) $display("[TB] FAIL sat_overflow got %h want 0004", overflow4);
        else n_pass++;
        n_checks++;
        if (cnt_flat !== exp_flat) $display("[TB] FAIL wide_counts got %h want %h", cnt_flat, exp_flat);
        else n_pass++;
        n_checks++;
        if (overflow !== 16'h0000) $display("[TB] FAIL wide_overflow got %h want 0000", overflow);
        else n_pass++;
        cnt_ready = 1'b1;
        step(1);
        cnt_ready = 1'b0;
    endtask

    task automatic test_handshake_hold();
        ro_in = '0;
        step(2);
        start = 1'b1; window_len = 8;
        step(1);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            ro_in[7] = (k == 1 || k == 2);
            step(1);
        end
        exp_flat = '0;
        exp_flat[7*CNT_W +: CNT_W] = 32'd1;
        for (int h = 0; h < 10; h++) begin
            n_checks++;
            if ({busy, cnt_valid} !== 2'b11) $display("[TB] FAIL hold_valid cyc %0d got busy=%b valid=%b want 1/1", h, busy, cnt_valid);
            else n_pass++;
            n_checks++;
            if (cnt_flat !== exp_flat) $display("[TB] FAIL hold_flat cyc %0d got %h want %h", h, cnt_flat, exp_flat);
            else n_pass++;
            if (h == 4) begin
                start = 1'b1; window_len = 8;
            end
            step(1);
            start = 1'b0;
        end
        start = 1'b1; cnt_ready = 1'b1;
        step(1);
        start = 1'b0; cnt_ready = 1'b0;
        n_checks++;
        if ({busy, cnt_valid} !== 2'b00) $display("[TB] FAIL hold_release got busy=%b valid=%b want 0/0", busy, cnt_valid);
        else n_pass++;
        step(2);
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL start_at_transfer got busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_abort_zero_window();
        start = 1'b1; window_len = 100;
        step(1);
        start = 1'b0;
        step(20);
        n_checks++;
        if (busy !== 1'b1) $display("[TB] FAIL abort_pre got busy=%b want 1", busy);
        else n_pass++;
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        n_checks++;
        if ({busy, cnt_valid} !== 2'b00) $display("[TB] FAIL abort_idle got busy=%b valid=%b want 0/0", busy, cnt_valid);
        else n_pass++;
        n_checks++;
        if (cnt_flat !== exp_flat) $display("[TB] FAIL abort_keeps_flat got %h want %h", cnt_flat, exp_flat);
        else n_pass++;
        step(90);
        n_checks++;
        if (cnt_valid !== 1'b0) $display("[TB] FAIL abort_no_snapshot got %b want 0", cnt_valid);
        else n_pass++;
        start = 1'b1; window_len = 0;
        step(1);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL zero_window got busy=%b want 0", busy);
        else n_pass++;
        step(2);
        start = 1'b1; abort = 1'b1; window_len = 8;
        step(1);
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("[TB] FAIL abort_in_idle got busy=%b want 1", busy);
        else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            ro_in[3] = (k == 1 || k == 2);
            step(1);
        end
        exp_flat = '0;
        exp_flat[3*CNT_W +: CNT_W] = 32'd1;
        n_checks++;
        if (cnt_valid !== 1'b1) $display("[TB] FAIL win8_valid got %b want 1", cnt_valid);
        else n_pass++;
        n_checks++;
        if (cnt_flat !== exp_flat) $display("[TB] FAIL win8_counts got %h want %h", cnt_flat, exp_flat);
        else n_pass++;
        cnt_ready = 1'b1;
        step(1);
        cnt_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        start = 1'b1; window_len = 50;
        step(1);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            ro_in[9] = (k >= 2 && k < 6);
            step(1);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, cnt_valid, overflow} !== {2'b00, 16'h0000})
            $display("[TB] FAIL rst_mid_ctrl got busy=%b valid=%b ovf=%h want 0/0/0000", busy, cnt_valid, overflow);
        else n_pass++;
        n_checks++;
        if (cnt_flat !== '0) $display("[TB] FAIL rst_mid_flat got %h want 0", cnt_flat);
        else n_pass++;
        ro_in = '0;
        step(3);
        rst = 1'b0;
        step(2);
        n_checks++;
        if ({busy, cnt_valid} !== 2'b00) $display("[TB] FAIL rst_mid_idle got busy=%b valid=%b want 0/0", busy, cnt_valid);
        else n_pass++;
        start = 1'b1; window_len = 20;
        step(1);
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            ro_in[9] = ((k >= 2 && k < 6) || (k >= 10 && k < 14));
            step(1);
        end
        exp_flat = '0;
        exp_flat[9*CNT_W +: CNT_W] = 32'd2;
        n_checks++;
        if (cnt_valid !== 1'b1) $display("[TB] FAIL post_rst_valid got %b want 1", cnt_valid);
        else n_pass++;
        n_checks++;
        if (cnt_flat !== exp_flat) $display("[TB] FAIL post_rst_counts got %h want %h", cnt_flat, exp_flat);
        else n_pass++;
        cnt_ready = 1'b1;
        step(1);
        cnt_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_isolated_pulses();
        test_max_rate();
        test_saturation();
        test_handshake_hold();
        test_abort_zero_window();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
